// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and IMEM.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// PC owner and instruction fetcher: fetch over req/ack, hold until advance,
// screen every redirect target and lock into a sticky fault on a bad one.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] IMEM_BASE = 32'h0000_3000,
    parameter logic [31:0] IMEM_SIZE = 32'h0000_1000
) (
    input  logic                       clk,
    input  logic                       reset,
    instr_fetch_unit_if.master         imem,
    input  logic [31:0]                next_pc,
    input  logic                       advance,
    output logic [31:0]                instr,
    output logic                       instr_valid,
    output logic [31:0]                pc,
    output logic [31:0]                pc_plus4,
    output logic                       fault,
    output logic [31:0]                fault_pc
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   capture, load_pc, take_fault;

    // Window bounds are widened to 33 bits so a window ending at 2^32 stays representable.
    function automatic logic legal_target(input logic [31:0] t);
        logic [32:0] lo;
        logic [32:0] hi;
        lo = {1'b0, IMEM_BASE};
        hi = {1'b0, IMEM_BASE} + {1'b0, IMEM_SIZE};
        return (t[1:0] == 2'b00) && ({1'b0, t} >= lo) && ({1'b0, t} < hi);
    endfunction

    always_comb begin
        state_nxt  = state;
        capture    = 1'b0;
        load_pc    = 1'b0;
        take_fault = 1'b0;
        case (state)
            FETCH: begin
                if (imem.imem_ack) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (advance) begin
                    if (legal_target(next_pc)) begin
                        load_pc   = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        take_fault = 1'b1;
                        state_nxt  = FAULT;
                    end
                end
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            fault_pc    <= 32'd0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                instr       <= imem.imem_rdata;
                instr_valid <= 1'b1;
            end
            if (load_pc) begin
                pc          <= next_pc;
                instr_valid <= 1'b0;
            end
            if (take_fault) begin
                fault       <= 1'b1;
                fault_pc    <= next_pc;
                instr_valid <= 1'b0;
            end
        end
    end

    assign imem.imem_req  = (state == FETCH);
    assign imem.imem_addr = pc;
    assign pc_plus4       = pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one task per scenario, inline checks.
module tb_instr_fetch_unit;
    logic        clk;
    logic        reset;
    logic [31:0] next_pc;
    logic        advance;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fault;
    logic [31:0] fault_pc;
    int          checks;
    int          failures;

    instr_fetch_unit_if imem_bus ();

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem_bus),
        .next_pc     (next_pc),
        .advance     (advance),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fault       (fault),
        .fault_pc    (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        advance = 1'b0;
        imem_bus.imem_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Zero-wait fetch of one word from the current FETCH state.
    task automatic fetch_word(input logic [31:0] data);
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = data;
        tick();
        imem_bus.imem_ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (imem_bus.imem_req !== 1'b1) begin failures++; $display("FAIL reset_req got=%b exp=1", imem_bus.imem_req); end
        checks++; if (imem_bus.imem_addr !== 32'h3000) begin failures++; $display("FAIL reset_addr got=%h exp=00003000", imem_bus.imem_addr); end
        checks++; if (instr_valid !== 1'b0 || fault !== 1'b0 || fault_pc !== 32'h0 || instr !== 32'h0) begin
            failures++; $display("FAIL reset_state valid=%b fault=%b fault_pc=%h instr=%h exp 0/0/0/0", instr_valid, fault, fault_pc, instr); end
        fetch_word(32'h3C01_1234);
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", instr_valid); end
        checks++; if (instr !== 32'h3C01_1234) begin failures++; $display("FAIL first_instr got=%h exp=3c011234", instr); end
        checks++; if (pc !== 32'h3000 || pc_plus4 !== 32'h3004) begin failures++; $display("FAIL first_pc got=%h/%h exp=00003000/00003004", pc, pc_plus4); end
        checks++; if (imem_bus.imem_req !== 1'b0) begin failures++; $display("FAIL hold_req got=%b exp=0", imem_bus.imem_req); end
    endtask

    task automatic test_delayed_ack();
        int req_cycles;
        do_reset();
        req_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (imem_bus.imem_req === 1'b1 && imem_bus.imem_addr === 32'h3000) req_cycles++;
            tick();
        end
        if (imem_bus.imem_req === 1'b1 && imem_bus.imem_addr === 32'h3000) req_cycles++;
        checks++; if (req_cycles !== 4) begin failures++; $display("FAIL delay_req_cycles got=%0d exp=4", req_cycles); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL delay_early_valid got=%b exp=0", instr_valid); end
        fetch_word(32'h1111_2222);
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h1111_2222) begin
            failures++; $display("FAIL delay_capture valid=%b instr=%h exp 1/11112222", instr_valid, instr); end
    endtask

    task automatic test_advance();
        next_pc = 32'h3010;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h3010) begin
            failures++; $display("FAIL advance_redirect valid=%b req=%b addr=%h exp 0/1/00003010", instr_valid, imem_bus.imem_req, imem_bus.imem_addr); end
        next_pc = 32'h3020;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        checks++; if (imem_bus.imem_addr !== 32'h3010 || pc !== 32'h3010 || imem_bus.imem_req !== 1'b1 || fault !== 1'b0) begin
            failures++; $display("FAIL advance_in_fetch addr=%h pc=%h req=%b fault=%b exp 00003010/00003010/1/0", imem_bus.imem_addr, pc, imem_bus.imem_req, fault); end
        fetch_word(32'h0000_ABCD);
        checks++; if (instr !== 32'h0000_ABCD || pc_plus4 !== 32'h3014) begin
            failures++; $display("FAIL advance_fetch instr=%h pc_plus4=%h exp 0000abcd/00003014", instr, pc_plus4); end
    endtask

    task automatic test_spurious_ack();
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_bus.imem_ack = 1'b0;
        checks++; if (instr !== 32'h0000_ABCD || instr_valid !== 1'b1 || imem_bus.imem_req !== 1'b0) begin
            failures++; $display("FAIL spurious_ack instr=%h valid=%b req=%b exp 0000abcd/1/0", instr, instr_valid, imem_bus.imem_req); end
        next_pc = 32'h3020;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h3020) begin
            failures++; $display("FAIL spurious_still_hold req=%b addr=%h exp 1/00003020", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    task automatic test_reset_during_fetch();
        tick();
        reset = 1'b1;
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 32'hCAFE_F00D;
        tick();
        reset = 1'b0;
        imem_bus.imem_ack = 1'b0;
        checks++; if (pc !== 32'h3000 || instr_valid !== 1'b0 || instr !== 32'h0) begin
            failures++; $display("FAIL reset_in_fetch pc=%h valid=%b instr=%h exp 00003000/0/00000000", pc, instr_valid, instr); end
        checks++; if (imem_bus.imem_req !== 1'b1) begin failures++; $display("FAIL reset_in_fetch_req got=%b exp=1", imem_bus.imem_req); end
    endtask

    task automatic test_fault();
        int req_seen;
        do_reset();
        fetch_word(32'h0000_0013);
        next_pc = 32'h3FFC;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        checks++; if (fault !== 1'b0 || imem_bus.imem_addr !== 32'h3FFC || imem_bus.imem_req !== 1'b1) begin
            failures++; $display("FAIL top_word_legal fault=%b addr=%h req=%b exp 0/00003ffc/1", fault, imem_bus.imem_addr, imem_bus.imem_req); end
        fetch_word(32'h0000_0013);
        next_pc = 32'h4000;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        checks++; if (fault !== 1'b1 || fault_pc !== 32'h4000 || pc !== 32'h3FFC || instr_valid !== 1'b0) begin
            failures++; $display("FAIL above_window fault=%b fault_pc=%h pc=%h valid=%b exp 1/00004000/00003ffc/0", fault, fault_pc, pc, instr_valid); end

        do_reset();
        fetch_word(32'h0000_0013);
        next_pc = 32'h2FFC;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        checks++; if (fault !== 1'b1 || fault_pc !== 32'h2FFC) begin
            failures++; $display("FAIL below_window fault=%b fault_pc=%h exp 1/00002ffc", fault, fault_pc); end

        do_reset();
        fetch_word(32'h0000_0013);
        next_pc = 32'h3002;
        advance = 1'b1;
        tick();
        checks++; if (fault !== 1'b1 || fault_pc !== 32'h3002 || pc !== 32'h3000) begin
            failures++; $display("FAIL misaligned fault=%b fault_pc=%h pc=%h exp 1/00003002/00003000", fault, fault_pc, pc); end
        req_seen = 0;
        next_pc = 32'h3010;
        for (int i = 0; i < 12; i++) begin
            imem_bus.imem_ack = i[0];
            imem_bus.imem_rdata = 32'h5555_0000 + i;
            if (imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0) req_seen++;
            tick();
        end
        advance = 1'b0;
        imem_bus.imem_ack = 1'b0;
        checks++; if (req_seen !== 0) begin failures++; $display("FAIL fault_terminal bad_cycles=%0d exp=0", req_seen); end
        checks++; if (fault !== 1'b1 || fault_pc !== 32'h3002 || pc !== 32'h3000) begin
            failures++; $display("FAIL fault_sticky fault=%b fault_pc=%h pc=%h exp 1/00003002/00003000", fault, fault_pc, pc); end
        do_reset();
        checks++; if (fault !== 1'b0 || imem_bus.imem_req !== 1'b1) begin
            failures++; $display("FAIL fault_cleared fault=%b req=%b exp 0/1", fault, imem_bus.imem_req); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        advance = 1'b0;
        next_pc = 32'h0;
        imem_bus.imem_ack = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        test_reset();
        test_delayed_ack();
        test_advance();
        test_spurious_ack();
        test_reset_during_fetch();
        test_fault();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
